// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
//
// Purpose:
//   Receives 8N1 UART frames (LSB first, line idle high) from an asynchronous
//   pin. Each correctly framed byte goes to the memory-access command engine
//   as a parallel byte plus a one-cycle strobe. The block also does three
//   line-quality jobs:
//     - synchronises the pin,
//     - rejects start bits that do not last to mid-bit,
//     - reports frames whose stop bit is sampled low.
//
// Ports:
//   clk        system clock; all logic on the rising edge
//   rst_n      synchronous active-low reset
//   rx         asynchronous serial input, idle high
//   RX_data    last correctly framed byte; holds between frames
//   byte_done  one-cycle pulse: RX_data was updated this cycle
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
// ---------------------------------------------------------------------------
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] RX_data,
    output logic       byte_done,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // Terminal counts: half a bit to reach the start-bit centre, then a
    // full bit between successive centre samples.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic             rx_s1_q, rx_s_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             byte_done_q, byte_done_d;
    logic             frame_err_q, frame_err_d;

    // Two-flop synchroniser. It resets to the idle level so that leaving
    // reset never looks like a start edge.
    // NOTE: clocked state is always written with non-blocking assignments
    // so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s_q  <= rx_s1_q;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s_q) state_d = ST_START;
            end

            ST_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        // Line went back high before mid-bit: a glitch.
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        rx_data_d   = shift_q;
                        byte_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            ST_BREAK: begin
                // Wait for a high level so a held-low line cannot be read
                // as a stream of new start bits.
                clk_cnt_d = '0;
                if (rx_s_q) state_d = ST_IDLE;
            end

            default: begin
                clk_cnt_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // NOTE: the shift register is cleared on reset along with the control
    // state, so a frame cut off by reset leaves no partial byte behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign RX_data   = rx_data_q;
    assign byte_done = byte_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframer
//
// Purpose:
//   Drives UART frames into uart_rx_deframer (CLKS_PER_BIT=16, 10 ns clock).
//   The traffic is a set of directed scenarios followed by random frames.
//   Expected results come from a frame-level model:
//     - each frame sent with a high stop bit must produce one byte_done,
//       carrying its byte;
//     - each frame sent with a low stop bit must produce one frame_err;
//     - either strobe must appear LAT cycles (+/-1) after the start edge.
//   Between strobes RX_data must hold the last good byte.
// ---------------------------------------------------------------------------
module tb_uart_rx_deframer;

    localparam int C   = 16;
    localparam int LAT = 2 + C / 2 + 9 * C + 1;
    localparam int TOL = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] RX_data;
    logic       byte_done;
    logic       frame_err;

    uart_rx_deframer #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .RX_data   (RX_data),
        .byte_done (byte_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_byte;
        logic [7:0] data;
        int         due;
    } ev_t;

    ev_t        exp_q[$];
    int         done_times[$];
    logic [7:0] exp_rx_data = 8'h00;
    int         cyc = 0;
    logic       rst_at_edge = 1'b0;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst_n;
    end

    // Output monitor: compares the strobes and the RX_data level against
    // the expected-event queue on every falling edge.
    always @(negedge clk) begin
        ev_t ev;
        if (!rst_at_edge) begin
            check("reset_rx_data", RX_data, 8'h00);
            check("reset_byte_done", byte_done, 1'b0);
            check("reset_frame_err", frame_err, 1'b0);
            exp_rx_data = 8'h00;
        end else begin
            if (exp_q.size() != 0 && cyc > exp_q[0].due + TOL) begin
                check("missed_event_cycle", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (byte_done || frame_err) begin
                check("strobes_exclusive", byte_done & frame_err, 1'b0);
                check("event_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    ev = exp_q.pop_front();
                    check("event_kind_is_byte", byte_done, ev.is_byte);
                    check("latency_in_window",
                          (cyc >= ev.due - TOL) && (cyc <= ev.due + TOL), 1'b1);
                    if (ev.is_byte) exp_rx_data = ev.data;
                end
                if (byte_done) done_times.push_back(cyc);
            end
            check("rx_data_level", RX_data, exp_rx_data);
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame and records the strobe it must produce. When glitch
    // is set, the first two cycles of every data bit carry the opposite
    // level. brk extra low cycles follow a low stop bit before the line
    // returns high.
    task automatic send(input logic [7:0] d, input bit stop, input bit glitch, input int brk);
        ev_t ev;
        ev.is_byte = stop;
        ev.data    = d;
        ev.due     = cyc + LAT;
        exp_q.push_back(ev);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (glitch) begin
                rx = ~d[i];
                repeat (2) @(negedge clk);
                rx = d[i];
                repeat (C - 2) @(negedge clk);
            end else begin
                rx = d[i];
                repeat (C) @(negedge clk);
            end
        end
        rx = stop;
        repeat (C) @(negedge clk);
        if (!stop) begin
            repeat (brk) @(negedge clk);
            idle(4);
        end
        rx = 1'b1;
    endtask

    initial begin
        int n0;
        logic [7:0] partial;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(20);

        // 1: single frame
        send(8'h0F, 1'b1, 1'b0, 0);
        idle(20);

        // 2: back-to-back frames, pulses one frame time apart
        n0 = done_times.size();
        send(8'hFF, 1'b1, 1'b0, 0);
        send(8'h00, 1'b1, 1'b0, 0);
        send(8'hA5, 1'b1, 1'b0, 0);
        idle(20);
        check("b2b_pulse_count", done_times.size() - n0, 3);
        if (done_times.size() - n0 == 3) begin
            check("b2b_spacing_1", done_times[n0 + 1] - done_times[n0], 10 * C);
            check("b2b_spacing_2", done_times[n0 + 2] - done_times[n0 + 1], 10 * C);
        end

        // 3: short start glitch rejected, then a good frame
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        send(8'h3C, 1'b1, 1'b0, 0);
        idle(20);

        // 4: framing error with a held-low line, then recovery
        send(8'h11, 1'b1, 1'b0, 0);
        send(8'h55, 1'b0, 1'b0, 40);
        idle(20);
        send(8'h3C, 1'b1, 1'b0, 0);
        idle(20);

        // 5: reset during data bit 4 of 0xC3 abandons the frame
        partial = 8'hC3;
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            repeat (C) @(negedge clk);
        end
        rx = partial[4];
        repeat (C / 2) @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        send(8'h81, 1'b1, 1'b0, 0);
        idle(20);

        // 6: glitches at data-bit edges are ignored
        send(8'hE7, 1'b1, 1'b1, 0);
        idle(20);

        // Random traffic
        for (int k = 0; k < 30; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                rx = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                idle(20);
            end else if (r == 1) begin
                send(8'($urandom), 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 40));
            end else begin
                send(8'($urandom), 1'b1, 1'($urandom_range(0, 1)), 0);
            end
            idle($urandom_range(0, 20));
        end

        idle(LAT + 20);
        check("events_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
